// File: rtl/icepic_fetch_seq.sv
// iCEPIC baseline fetch/sequencing controller: Q-phase generator, program
// counter, 2-level return stack and 1-word fetch/execute pipeline.
// Optional build macro ICEPIC_STACK_ERR_EN adds a sticky stack_err output
// that flags stack overflow/underflow.
module icepic_fetch_seq #(
    parameter int unsigned     PC_W         = 9,
    parameter logic [PC_W-1:0] RESET_VECTOR = 9'h1FF,
    parameter int unsigned     STACK_DEPTH  = 2   // fixed at 2 levels
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] pmem_addr,
    input  logic [11:0]     pmem_rdata,
    input  logic            skip_req,
    input  logic            pcl_we,
    input  logic [7:0]      pcl_wdata,
    output logic [3:0]      q_phase,
    output logic            cycle_end,
    output logic [11:0]     inst_exec,
    output logic [PC_W-1:0] pc_out
`ifdef ICEPIC_STACK_ERR_EN
    ,
    output logic            stack_err
`endif
);

    typedef enum logic [3:0] {
        StQ1 = 4'b0001,
        StQ2 = 4'b0010,
        StQ3 = 4'b0100,
        StQ4 = 4'b1000
    } q_e;

    q_e              q_q;
    logic            cycle_end_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [11:0]     ir_q;
    logic [PC_W-1:0] stack_q [STACK_DEPTH];

    logic [3:0] op;
    logic       flush;
    logic       push;
    logic       pop;

`ifdef ICEPIC_STACK_ERR_EN
    logic [1:0] occ_q;
    logic       err_q;
`endif

    assign op        = ir_q[11:8];
    assign pmem_addr = pc_q;
    assign pc_out    = pc_q;
    assign q_phase   = q_q;
    assign cycle_end = cycle_end_q;
    assign inst_exec = ir_q;

    // Resolve next PC from the executing opcode first, then datapath requests.
    always_comb begin
        pc_d  = pc_q + 1'b1;
        flush = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        if (op == 4'hA || op == 4'hB) begin
            pc_d  = PC_W'(ir_q[8:0]);
            flush = 1'b1;
        end else if (op == 4'h9) begin
            pc_d  = PC_W'(ir_q[7:0]);
            push  = 1'b1;
            flush = 1'b1;
        end else if (op == 4'h8) begin
            pc_d  = stack_q[0];
            pop   = 1'b1;
            flush = 1'b1;
        end else if (pcl_we) begin
            pc_d  = PC_W'(pcl_wdata);
            flush = 1'b1;
        end else if (skip_req) begin
            flush = 1'b1;
        end
    end

    // Q-phase sequencer; PC, IR and stack only move on the edge ending Q4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q         <= StQ1;
            cycle_end_q <= 1'b0;
            pc_q        <= RESET_VECTOR;
            ir_q        <= 12'h000;
            stack_q[0]  <= '0;
            stack_q[1]  <= '0;
        end else begin
            cycle_end_q <= (q_q == StQ3);
            unique case (q_q)
                StQ1: q_q <= StQ2;
                StQ2: q_q <= StQ3;
                StQ3: q_q <= StQ4;
                StQ4: begin
                    q_q  <= StQ1;
                    pc_q <= pc_d;
                    ir_q <= flush ? 12'h000 : pmem_rdata;
                    // pc_q already points past the CALL, so it is the return address.
                    if (push) begin
                        stack_q[1] <= stack_q[0];
                        stack_q[0] <= pc_q;
                    end else if (pop) begin
                        stack_q[0] <= stack_q[1];
                    end
                end
                default: q_q <= StQ1;
            endcase
        end
    end

`ifdef ICEPIC_STACK_ERR_EN
    // Occupancy tracking (saturating 0..2) and sticky overflow/underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= 2'd0;
            err_q <= 1'b0;
        end else if (q_q == StQ4) begin
            if (push) begin
                if (occ_q == 2'd2) begin
                    err_q <= 1'b1;
                end else begin
                    occ_q <= occ_q + 2'd1;
                end
            end else if (pop) begin
                if (occ_q == 2'd0) begin
                    err_q <= 1'b1;
                end else begin
                    occ_q <= occ_q - 2'd1;
                end
            end
        end
    end

    assign stack_err = err_q;
`endif

endmodule

// File: tb/tb_icepic_fetch_seq.sv
// Self-checking bench for icepic_fetch_seq: per-scenario tasks push the
// expected (fetch address, executing opcode) per instruction cycle into a
// scoreboard queue and pop/compare at Q1 of each cycle.
module tb_icepic_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic [8:0]  pmem_addr;
    logic [11:0] pmem_rdata;
    logic        skip_req;
    logic        pcl_we;
    logic [7:0]  pcl_wdata;
    logic [3:0]  q_phase;
    logic        cycle_end;
    logic [11:0] inst_exec;
    logic [8:0]  pc_out;
`ifdef ICEPIC_STACK_ERR_EN
    logic        stack_err;
`endif

    logic [11:0] rom [0:511];

    typedef struct packed {
        logic [8:0]  pc;
        logic [11:0] ex;
    } exp_t;

    exp_t sbq[$];

    int checks   = 0;
    int failures = 0;

    icepic_fetch_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pmem_addr  (pmem_addr),
        .pmem_rdata (pmem_rdata),
        .skip_req   (skip_req),
        .pcl_we     (pcl_we),
        .pcl_wdata  (pcl_wdata),
        .q_phase    (q_phase),
        .cycle_end  (cycle_end),
        .inst_exec  (inst_exec),
        .pc_out     (pc_out)
`ifdef ICEPIC_STACK_ERR_EN
        ,
        .stack_err  (stack_err)
`endif
    );

    assign pmem_rdata = rom[pmem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_rom();
        for (int i = 0; i < 512; i++) rom[i] = 12'h000;
    endtask

    // Leaves the bench at the Q1 sample point of instruction cycle 0.
    task automatic do_reset();
        rst_n     = 1'b0;
        skip_req  = 1'b0;
        pcl_we    = 1'b0;
        pcl_wdata = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Moves from one Q1 sample point to the next.
    task automatic advance();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [8:0] pc, input logic [11:0] ex);
        exp_t e;
        e.pc = pc;
        e.ex = ex;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        int   cyc;
        clear_rom();
        rst_n = 1'b0;
        skip_req = 1'b0;
        pcl_we = 1'b0;
        pcl_wdata = 8'h00;
        @(negedge clk);
        checks++;
        if (q_phase !== 4'b0001 || cycle_end !== 1'b0 || inst_exec !== 12'h000 ||
            pmem_addr !== 9'h1FF) begin
            failures++;
            $display("FAIL reset_state q=%b ce=%b ex=%h pc=%h req q=0001 ce=0 ex=000 pc=1ff",
                     q_phase, cycle_end, inst_exec, pmem_addr);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_phase !== (4'b0001 << i) || cycle_end !== (i == 3) ||
                pmem_addr !== 9'h1FF) begin
                failures++;
                $display("FAIL q_seq i=%0d q=%b ce=%b pc=%h req q=%b ce=%b pc=1ff",
                         i, q_phase, cycle_end, pmem_addr, 4'b0001 << i, i == 3);
            end
            @(negedge clk);
        end
        push_exp(9'h000, 12'h000);
        push_exp(9'h001, 12'h000);
        push_exp(9'h002, 12'h000);
        cyc = 1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (pmem_addr !== e.pc || pc_out !== e.pc || inst_exec !== e.ex) begin
                failures++;
                $display("FAIL reset_wrap cyc=%0d pc=%h pc_out=%h ex=%h req pc=%h ex=%h",
                         cyc, pmem_addr, pc_out, inst_exec, e.pc, e.ex);
            end
            advance();
            cyc++;
        end
        // Mid-cycle reset must abort immediately back to Q1 / reset vector.
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (q_phase !== 4'b0001 || pmem_addr !== 9'h1FF || inst_exec !== 12'h000) begin
            failures++;
            $display("FAIL midcycle_reset q=%b pc=%h ex=%h req q=0001 pc=1ff ex=000",
                     q_phase, pmem_addr, inst_exec);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_goto();
        exp_t e;
        int   cyc;
        clear_rom();
        rom[9'h005] = 12'hA40;
        rom[9'h040] = 12'h123;
        push_exp(9'h1FF, 12'h000);
        for (int i = 0; i <= 5; i++) push_exp(9'(i), 12'h000);
        push_exp(9'h006, 12'hA40);
        push_exp(9'h040, 12'h000);
        push_exp(9'h041, 12'h123);
        push_exp(9'h042, 12'h000);
        do_reset();
        cyc = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (pmem_addr !== e.pc || pc_out !== e.pc || inst_exec !== e.ex) begin
                failures++;
                $display("FAIL goto cyc=%0d pc=%h pc_out=%h ex=%h req pc=%h ex=%h",
                         cyc, pmem_addr, pc_out, inst_exec, e.pc, e.ex);
            end
            // A PCL write during GOTO must lose to the GOTO.
            if (cyc == 7) begin
                pcl_we    = 1'b1;
                pcl_wdata = 8'h77;
            end else begin
                pcl_we    = 1'b0;
            end
            advance();
            cyc++;
        end
    endtask

    task automatic test_call_retlw();
        exp_t e;
        int   cyc;
        clear_rom();
        rom[9'h000] = 12'hA10;
        rom[9'h010] = 12'h920;
        rom[9'h011] = 12'h2AB;
        rom[9'h020] = 12'h855;
        push_exp(9'h1FF, 12'h000);
        push_exp(9'h000, 12'h000);
        push_exp(9'h001, 12'hA10);
        push_exp(9'h010, 12'h000);
        push_exp(9'h011, 12'h920);
        push_exp(9'h020, 12'h000);
        push_exp(9'h021, 12'h855);
        push_exp(9'h011, 12'h000);
        push_exp(9'h012, 12'h2AB);
        push_exp(9'h013, 12'h000);
        do_reset();
        cyc = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (pmem_addr !== e.pc || pc_out !== e.pc || inst_exec !== e.ex) begin
                failures++;
                $display("FAIL call_retlw cyc=%0d pc=%h pc_out=%h ex=%h req pc=%h ex=%h",
                         cyc, pmem_addr, pc_out, inst_exec, e.pc, e.ex);
            end
            advance();
            cyc++;
        end
    endtask

    task automatic test_skip();
        exp_t e;
        int   cyc;
        clear_rom();
        rom[9'h000] = 12'hA30;
        rom[9'h030] = 12'h2F0;
        rom[9'h031] = 12'h3AA;
        rom[9'h032] = 12'h1C5;
        push_exp(9'h1FF, 12'h000);
        push_exp(9'h000, 12'h000);
        push_exp(9'h001, 12'hA30);
        push_exp(9'h030, 12'h000);
        push_exp(9'h031, 12'h2F0);
        push_exp(9'h032, 12'h000);
        push_exp(9'h033, 12'h1C5);
        do_reset();
        cyc = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (pmem_addr !== e.pc || pc_out !== e.pc || inst_exec !== e.ex) begin
                failures++;
                $display("FAIL skip cyc=%0d pc=%h pc_out=%h ex=%h req pc=%h ex=%h",
                         cyc, pmem_addr, pc_out, inst_exec, e.pc, e.ex);
            end
            skip_req = (cyc == 4);
            advance();
            cyc++;
        end
    endtask

    task automatic test_pcl_write();
        exp_t e;
        int   cyc;
        clear_rom();
        rom[9'h000] = 12'hBA0;
        rom[9'h1A0] = 12'h2FF;
        rom[9'h0C3] = 12'h155;
        push_exp(9'h1FF, 12'h000);
        push_exp(9'h000, 12'h000);
        push_exp(9'h001, 12'hBA0);
        push_exp(9'h1A0, 12'h000);
        push_exp(9'h0C3, 12'h000);
        push_exp(9'h0C4, 12'h155);
        do_reset();
        cyc = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (pmem_addr !== e.pc || pc_out !== e.pc || inst_exec !== e.ex) begin
                failures++;
                $display("FAIL pcl_write cyc=%0d pc=%h pc_out=%h ex=%h req pc=%h ex=%h",
                         cyc, pmem_addr, pc_out, inst_exec, e.pc, e.ex);
            end
            pcl_we    = (cyc == 3);
            pcl_wdata = (cyc == 3) ? 8'hC3 : 8'h00;
            advance();
            cyc++;
        end
    endtask

    task automatic test_stack_overflow();
        exp_t e;
        int   cyc;
        clear_rom();
        rom[9'h000] = 12'hA10;
        rom[9'h010] = 12'h920;
        rom[9'h020] = 12'h930;
        rom[9'h030] = 12'h940;
        rom[9'h040] = 12'h801;
        rom[9'h031] = 12'h802;
        rom[9'h021] = 12'h803;
        push_exp(9'h1FF, 12'h000);
        push_exp(9'h000, 12'h000);
        push_exp(9'h001, 12'hA10);
        push_exp(9'h010, 12'h000);
        push_exp(9'h011, 12'h920);
        push_exp(9'h020, 12'h000);
        push_exp(9'h021, 12'h930);
        push_exp(9'h030, 12'h000);
        push_exp(9'h031, 12'h940);
        push_exp(9'h040, 12'h000);
        push_exp(9'h041, 12'h801);
        push_exp(9'h031, 12'h000);
        push_exp(9'h032, 12'h802);
        push_exp(9'h021, 12'h000);
        push_exp(9'h022, 12'h803);
        push_exp(9'h021, 12'h000);
        do_reset();
        cyc = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (pmem_addr !== e.pc || pc_out !== e.pc || inst_exec !== e.ex) begin
                failures++;
                $display("FAIL stack cyc=%0d pc=%h pc_out=%h ex=%h req pc=%h ex=%h",
                         cyc, pmem_addr, pc_out, inst_exec, e.pc, e.ex);
            end
`ifdef ICEPIC_STACK_ERR_EN
            checks++;
            if (stack_err !== (cyc >= 9)) begin
                failures++;
                $display("FAIL stack_err cyc=%0d got=%b req=%b", cyc, stack_err, cyc >= 9);
            end
`endif
            advance();
            cyc++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        skip_req  = 1'b0;
        pcl_we    = 1'b0;
        pcl_wdata = 8'h00;
        clear_rom();
        test_reset();
        test_goto();
        test_call_retlw();
        test_skip();
        test_pcl_write();
        test_stack_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
